// File: rtl/experience.sv
// Multi-channel edge capture: per-channel synchroniser, selectable edge detect,
// saturating pending counters, drained round-robin through a registered event slot.
module experience #(
    parameter int NCH  = 3,
    parameter int CW   = 4,
    parameter int SYNC = 2
) (
    input  logic                                     mclk,
    input  logic                                     resetb,
    input  logic                                     enable,
    input  logic                                     clr,
    input  logic [1:0]                               edge_sel,
    input  logic [NCH-1:0]                           chan_in,
    input  logic                                     evt_ready,
    output logic                                     evt_valid,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] evt_chan,
    output logic [CW-1:0]                            evt_count,
    output logic [NCH-1:0]                           level,
    output logic [NCH-1:0]                           overflow
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] PEND_MAX = {CW{1'b1}};

    logic [NCH-1:0] sync_q [SYNC];
    logic [NCH-1:0] sync_d [SYNC];
    logic [NCH-1:0] prev_q, prev_d;
    logic [CW-1:0]  pend_q [NCH];
    logic [CW-1:0]  pend_d [NCH];
    logic [NCH-1:0] ovf_q, ovf_d;
    logic [CHW-1:0] rr_ptr_q, rr_ptr_d;
    logic           evt_valid_q, evt_valid_d;
    logic [CHW-1:0] evt_chan_q, evt_chan_d;
    logic [CW-1:0]  evt_count_q, evt_count_d;

    logic [NCH-1:0] lvl, rise, fall, det, cnt_ev;
    logic           load_ok, grant_found;
    logic [CHW-1:0] grant_idx;
    int             scan_j;

    always_comb begin
        sync_d[0] = chan_in;
        for (int i = 1; i < SYNC; i++) sync_d[i] = sync_q[i-1];
    end

    assign lvl    = sync_q[SYNC-1];
    assign prev_d = lvl;
    assign rise   = lvl & ~prev_q;
    assign fall   = ~lvl & prev_q;

    always_comb begin
        case (edge_sel)
            2'b00:   det = rise;
            2'b01:   det = fall;
            2'b10:   det = rise | fall;
            default: det = '0;
        endcase
    end

    assign cnt_ev = det & {NCH{enable & ~clr}};

    // First pending channel at or after rr_ptr, wrapping; lowest offset wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_j      = 0;
        for (int i = NCH - 1; i >= 0; i--) begin
            scan_j = int'(rr_ptr_q) + i;
            if (scan_j >= NCH) scan_j = scan_j - NCH;
            if (pend_q[scan_j] != '0) begin
                grant_found = 1'b1;
                grant_idx   = CHW'(scan_j);
            end
        end
    end

    // Event port: a transfer happens on a rising mclk when evt_valid and evt_ready
    // are both 1; while evt_valid is 1 and evt_ready is 0 the slot contents hold.
    always_comb begin
        load_ok     = !evt_valid_q || evt_ready;
        pend_d      = pend_q;
        ovf_d       = ovf_q;
        rr_ptr_d    = rr_ptr_q;
        evt_valid_d = evt_valid_q;
        evt_chan_d  = evt_chan_q;
        evt_count_d = evt_count_q;

        for (int c = 0; c < NCH; c++) begin
            if (cnt_ev[c]) begin
                if (pend_q[c] == PEND_MAX) ovf_d[c] = 1'b1;
                else                       pend_d[c] = pend_q[c] + 1'b1;
            end
        end

        if (load_ok) begin
            if (grant_found) begin
                evt_valid_d       = 1'b1;
                evt_chan_d        = grant_idx;
                evt_count_d       = pend_q[grant_idx];
                pend_d[grant_idx] = cnt_ev[grant_idx] ? CW'(1) : '0;
                ovf_d[grant_idx]  = ovf_q[grant_idx];
                rr_ptr_d          = (grant_idx == CHW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
            end else begin
                evt_valid_d = 1'b0;
            end
        end

        // Clear beats both counting and the grant's counter reload.
        if (clr) begin
            pend_d = '{default: '0};
            ovf_d  = '0;
        end
    end

    always_ff @(posedge mclk or posedge resetb) begin
        if (resetb) begin
            sync_q      <= '{default: '0};
            prev_q      <= '0;
            pend_q      <= '{default: '0};
            ovf_q       <= '0;
            rr_ptr_q    <= '0;
            evt_valid_q <= 1'b0;
            evt_chan_q  <= '0;
            evt_count_q <= '0;
        end else begin
            sync_q      <= sync_d;
            prev_q      <= prev_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            rr_ptr_q    <= rr_ptr_d;
            evt_valid_q <= evt_valid_d;
            evt_chan_q  <= evt_chan_d;
            evt_count_q <= evt_count_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_chan  = evt_chan_q;
    assign evt_count = evt_count_q;
    assign level     = lvl;
    assign overflow  = ovf_q;

endmodule

// File: doc/experience.md
# experience

Parametrised multi-channel event capture block, the next generation of the single-set guitarist port modules. It accepts NCH asynchronous channel inputs, synchronises them, detects edges in a run-time selectable mode, and counts pending events per channel in saturating counters. A round-robin arbiter drains the counters through a registered valid/ready event port, so no edge is lost while downstream stalls, up to counter saturation. Sits between raw board-level inputs and the status-collection logic.

## Interface
- NCH, 3, number of channels (1..16)
- CW, 4, pending-counter and evt_count width (2..8)
- SYNC, 2, synchroniser depth (2 or 3)
- CHW, max(1,$clog2(NCH)), channel index width (derived, not overridden)

- mclk  in  1  clock, rising edge
- resetb  in  1  asynchronous reset, active-high (port name kept; asserted = 1)
- enable  in  1  1 = count detected edges
- clr  in  1  synchronous clear of pending counters and overflow
- edge_sel  in  2  00 rising, 01 falling, 10 both, 11 none
- chan_in  in  NCH  asynchronous channel inputs
- evt_ready  in  1  downstream accepts event
- evt_valid  out  1  event slot holds data
- evt_chan  out  CHW  channel index of event
- evt_count  out  CW  number of edges drained for that channel (1..2^CW-1)
- level  out  NCH  synchronised channel levels
- overflow  out  NCH  sticky: edge arrived while channel counter saturated

## Operation
- Per channel: SYNC-stage flop chain s, previous-level flop p; level = last sync stage. Edge detected combinationally from last stage vs p, per edge_sel. p updates every cycle regardless of enable.
- Pending counter pend[c]: increments on detected edge when enable=1 and clr=0. At 2^CW-1 it holds and sets overflow[c].
- Output slot: loads when evt_valid=0 or (evt_valid & evt_ready). Arbiter scans from rr_ptr upward (wrapping at NCH-1 -> 0) for first c with pend[c]!=0; loads evt_chan=c, evt_count=pend[c], sets evt_valid=1, rr_ptr <= c+1 (wrap), pend[c] <= 0, or 1 if an edge on c is counted the same cycle (no overflow then).
- No pending channel at load opportunity: evt_valid <= 0 if accepted; slot otherwise unchanged.
- evt_valid & !evt_ready: evt_chan and evt_count held stable; valid never drops without acceptance.
- clr: pend and overflow to 0 next cycle; same-cycle edges dropped; output slot and rr_ptr unaffected, and the slot may still load from pre-clear pend values that cycle; clr wins over the load-clear for pend.
- enable=0: no counting; draining continues. Re-enable produces no spurious edge, since p tracked.
- edge_sel change takes effect on the next detection cycle.
- Reset (any time, including mid-handshake): s, p, pend, overflow, rr_ptr, evt_valid, evt_chan, evt_count all 0; level = 0, overflow = 0, evt_valid = 0. A channel held high across reset release yields one rising event in modes 00/10.

## Timing
- chan_in first sampled high at edge k: level high after edge k+SYNC-1; pend increments at edge k+SYNC; evt_valid high after edge k+SYNC+1 if slot free. Latency SYNC+1 cycles.
- Back-to-back acceptance: one event per cycle while evt_ready=1 and channels pending.
- Input pulses shorter than one mclk period are not guaranteed to be detected.
- Fairness: with all channels continuously pending, each channel is granted once per NCH accepted events.

## Test plan
- Reset check: resetb=1 with chan_in=3'b101 -> all outputs 0. Release, mode 00 -> events for ch0 then ch2, each evt_count=1.
- Latency: SYNC=2, ch1 rises, evt_ready=1 -> evt_valid after 3 cycles, evt_chan=1, evt_count=1, deasserts one cycle later.
- Stall and accumulate: evt_ready=0, 5 rising edges on ch0 in mode 00 -> single event held stable with count 1, then after accept a second event with count 4. With CW=4 and 20 edges: pend=15, overflow[0]=1 until clr.
- Mode 10 with 3 toggles on ch2 -> total drained count 3. Mode 11 -> no events. Mode 01 -> only falling edges counted.
- Round robin: all three channels pending, evt_ready=1 -> grant order 0,1,2,0... with rr_ptr wrap. An edge on a channel coinciding with its load -> pend=1, follow-up event.
- Mid-stream: clr during a stall -> held event still delivered, pend/overflow 0. resetb pulse while evt_valid=1 -> evt_valid=0 immediately, no event after release except for inputs held high.
